// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state encoding, header field layout and sizing helper for the UART
// transmit arbiter and its round-robin picker.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_DATA   = 2'd2
   } arb_state_e;

   // Header byte layout: {zeros, source id, length field}, length in the LSBs.
   localparam int HDR_LEN_LSB = 0;

   function automatic int hdr_id_lsb(input int len_width);
      return HDR_LEN_LSB + len_width;
   endfunction

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: lowest requesting index at or after ptr
// wins, wrapping around; reports the winner as one-hot and as an index.
module rr_priority_select #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      // Wrapped region first, then the region at/after ptr overrides it.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i] && (i < int'(ptr))) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = IW'(i);
            valid     = 1'b1;
         end
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i] && (i >= int'(ptr))) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = IW'(i);
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART transmit port.
// Define UART_ARB_HEADER_EN to prefix every message with an {id, len} header byte.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 8,
   parameter int LEN_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*LEN_WIDTH-1:0] req_len,
   input  logic [NUM_REQ*WIDTH-1:0]     req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [WIDTH-1:0]             uart_data,
   output logic                         uart_valid,
   input  logic                         uart_ready,
   output logic [NUM_REQ-1:0]           grant,
   output logic                         busy
);

   localparam int IDX_W = clog2(NUM_REQ);

   arb_state_e           state_reg, state_next;
   logic [LEN_WIDTH-1:0] count_reg, count_next;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [IDX_W-1:0]     ptr_reg, ptr_next;
   logic [NUM_REQ-1:0]   grant_reg, grant_next;

   logic [NUM_REQ-1:0]   pick_onehot;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_valid;
   logic                 data_hs;

   logic [WIDTH-1:0]     data_arr [NUM_REQ];
   logic [LEN_WIDTH-1:0] len_arr  [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign data_arr[gi]  = req_data[gi*WIDTH +: WIDTH];
         assign len_arr[gi]   = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
         assign req_ready[gi] = (state_reg == ST_DATA) & grant_reg[gi] & uart_ready;
      end
   endgenerate

   rr_priority_select #(
      .N  (NUM_REQ),
      .IW (IDX_W)
   ) u_pick (
      .req    (req_valid),
      .ptr    (ptr_reg),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

`ifdef UART_ARB_HEADER_EN
   logic [WIDTH-1:0] header_word;

   if (IDX_W + LEN_WIDTH > WIDTH) begin : g_hdr_check
      $error("uart_tx_arbiter: id and length fields do not fit in one UART word");
   end

   always_comb begin
      header_word = '0;
      header_word[HDR_LEN_LSB +: LEN_WIDTH]       = count_reg;
      header_word[hdr_id_lsb(LEN_WIDTH) +: IDX_W] = idx_reg;
   end
`endif

   assign data_hs = (state_reg == ST_DATA) & req_valid[idx_reg] & uart_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         count_reg <= '0;
         idx_reg   <= '0;
         ptr_reg   <= '0;
         grant_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         idx_reg   <= idx_next;
         ptr_reg   <= ptr_next;
         grant_reg <= grant_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      idx_next   = idx_reg;
      ptr_next   = ptr_reg;
      grant_next = grant_reg;
      case (state_reg)
         ST_IDLE: begin
            if (pick_valid) begin
               count_next = len_arr[pick_idx];
               idx_next   = pick_idx;
               grant_next = pick_onehot;
`ifdef UART_ARB_HEADER_EN
               state_next = ST_HEADER;
`else
               state_next = ST_DATA;
`endif
            end
         end
`ifdef UART_ARB_HEADER_EN
         ST_HEADER: begin
            if (uart_ready) state_next = ST_DATA;
         end
`endif
         ST_DATA: begin
            if (data_hs) begin
               // count holds bytes remaining after this one; zero means last byte.
               if (count_reg == '0) begin
                  state_next = ST_IDLE;
                  grant_next = '0;
                  ptr_next   = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + 1'b1;
               end else begin
                  count_next = count_reg - 1'b1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      uart_data  = '0;
      uart_valid = 1'b0;
      case (state_reg)
`ifdef UART_ARB_HEADER_EN
         ST_HEADER: begin
            uart_data  = header_word;
            uart_valid = 1'b1;
         end
`endif
         ST_DATA: begin
            uart_data  = data_arr[idx_reg];
            uart_valid = req_valid[idx_reg];
         end
         default: ;
      endcase
   end

   assign grant = grant_reg;
   assign busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter against a message-level
// model of the channel owner; follows UART_ARB_HEADER_EN like the design.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int W  = 8;
   localparam int LW = 4;
`ifdef UART_ARB_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic             clk;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR*LW-1:0] req_len;
   logic [NR*W-1:0]  req_data;
   logic [NR-1:0]    req_ready;
   logic [W-1:0]     uart_data;
   logic             uart_valid;
   logic             uart_ready;
   logic [NR-1:0]    grant;
   logic             busy;

   uart_tx_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LEN_WIDTH(LW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_len    (req_len),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .uart_data  (uart_data),
      .uart_valid (uart_valid),
      .uart_ready (uart_ready),
      .grant      (grant),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Model: who owns the channel, bytes still owed, header still owed.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_left  = 0;
   int m_len   = 0;
   bit m_hdr   = 1'b0;

   // Producers: queued messages per requester.
   int          q_len   [NR][$];
   logic [7:0]  q_bytes [NR][$];
   int          pos       [NR];
   int          stall_cnt [NR];
   bit          rand_stall[NR];
   int          stall_pct   = 0;
   int          ready_mode  = 0;
   bit          garbage_len = 1'b0;

   logic [7:0]  log_q[$];
   int          gnt_q[$];
   logic [7:0]  exp_q[$];
   int          exp_g[$];
   logic [NR-1:0] prev_grant = '0;

   task automatic enq(input int i, input int len, input int base);
      q_len[i].push_back(len);
      for (int b = 0; b <= len; b++) q_bytes[i].push_back(8'(base + b));
   endtask

   task automatic exp_msg(input int id, input int len, input int base);
      if (HDR != 0) exp_q.push_back(8'((id << LW) | len));
      for (int b = 0; b <= len; b++) exp_q.push_back(8'(base + b));
   endtask

   task automatic clear_logs();
      log_q.delete();
      gnt_q.delete();
      exp_q.delete();
      exp_g.delete();
   endtask

   task automatic flush_producers();
      for (int i = 0; i < NR; i++) begin
         q_len[i].delete();
         q_bytes[i].delete();
         pos[i] = 0;
         stall_cnt[i] = 0;
         rand_stall[i] = 1'b0;
      end
      prev_grant = '0;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NR; i++) begin
         req_valid[i] = 1'b0;
         req_len[i*LW +: LW] = '0;
         req_data[i*W +: W] = '0;
         if (q_len[i].size() > 0) begin
            req_len[i*LW +: LW] = LW'(q_len[i][0]);
            req_data[i*W +: W]  = q_bytes[i][pos[i]];
            req_valid[i] = (stall_cnt[i] == 0) && !rand_stall[i];
            if (garbage_len && m_owner == i) req_len[i*LW +: LW] = LW'($urandom);
         end
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, want);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic check_stream(input string name);
      int bad;
      int n;
      bad = -1;
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      vectors++;
      for (int i = 0; i < n; i++) if (bad < 0 && log_q[i] !== exp_q[i]) bad = i;
      if (bad < 0 && log_q.size() != exp_q.size()) bad = n;
      if (bad >= 0) begin
         miscompares++;
         $display("FAIL %s: got %0d bytes, want %0d, first difference at byte %0d (got %0h want %0h)",
                  name, log_q.size(), exp_q.size(), bad,
                  (bad < log_q.size()) ? log_q[bad] : 8'h00,
                  (bad < exp_q.size()) ? exp_q[bad] : 8'h00);
      end else begin
         $display("ok   %s: %0d bytes", name, log_q.size());
      end
   endtask

   task automatic check_grants(input string name);
      bit ok;
      ok = (gnt_q.size() == exp_g.size());
      vectors++;
      for (int i = 0; i < gnt_q.size() && i < exp_g.size(); i++) if (gnt_q[i] != exp_g[i]) ok = 1'b0;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: got %0d grants (first %0d), want %0d (first %0d)", name,
                  gnt_q.size(), (gnt_q.size() > 0) ? gnt_q[0] : -1,
                  exp_g.size(), (exp_g.size() > 0) ? exp_g[0] : -1);
      end else begin
         $display("ok   %s: %0d grants in order", name, gnt_q.size());
      end
   endtask

   // One clock cycle: compare at negedge, then advance model and producers.
   task automatic step();
      logic [NR-1:0] exp_grant, exp_ready;
      logic          exp_valid, exp_busy;
      logic [W-1:0]  exp_data;
      int            gidx;
      @(negedge clk);
      cyc++;
      exp_grant = '0; exp_ready = '0; exp_valid = 1'b0; exp_busy = 1'b0; exp_data = '0;
      if (rst_n && m_owner >= 0) begin
         exp_busy = 1'b1;
         exp_grant[m_owner] = 1'b1;
         if (m_hdr) begin
            exp_valid = 1'b1;
            exp_data  = 8'((m_owner << LW) | m_len);
         end else begin
            exp_valid = req_valid[m_owner];
            exp_data  = req_data[m_owner*W +: W];
            exp_ready[m_owner] = uart_ready;
         end
      end
      vectors++;
      if (grant !== exp_grant || busy !== exp_busy || uart_valid !== exp_valid ||
          req_ready !== exp_ready || uart_data !== exp_data) begin
         miscompares++;
         $display("FAIL cycle %0d: got grant=%b busy=%b valid=%b ready=%b data=%h, want grant=%b busy=%b valid=%b ready=%b data=%h",
                  cyc, grant, busy, uart_valid, req_ready, uart_data,
                  exp_grant, exp_busy, exp_valid, exp_ready, exp_data);
      end
      if (uart_valid === 1'b1 && uart_ready) log_q.push_back(uart_data);
      if (grant != '0 && prev_grant == '0) begin
         gidx = -1;
         for (int i = 0; i < NR; i++) if (grant[i]) gidx = i;
         gnt_q.push_back(gidx);
      end
      prev_grant = grant;

      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_owner = -1; m_ptr = 0; m_left = 0; m_hdr = 1'b0; m_len = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (m_owner < 0 && req_valid[i]) begin
               m_owner = i;
               m_len   = int'(req_len[i*LW +: LW]);
               m_left  = m_len + 1;
               m_hdr   = (HDR != 0);
            end
         end
      end else if (m_hdr) begin
         if (uart_ready) m_hdr = 1'b0;
      end else if (req_valid[m_owner] && uart_ready) begin
         m_left--;
         if (m_left == 0) begin
            m_ptr = (m_owner + 1) % NR;
            m_owner = -1;
         end
      end
      for (int i = 0; i < NR; i++) begin
         if (exp_ready[i] && req_valid[i]) begin
            pos[i]++;
            if (pos[i] == q_len[i][0] + 1) begin
               for (int b = 0; b < pos[i]; b++) void'(q_bytes[i].pop_front());
               void'(q_len[i].pop_front());
               pos[i] = 0;
            end
         end
         if (stall_cnt[i] > 0) stall_cnt[i]--;
         rand_stall[i] = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
      end
      case (ready_mode)
         0: uart_ready = 1'b1;
         1: uart_ready = ~uart_ready;
         default: uart_ready = 1'($urandom_range(1));
      endcase
      drive_inputs();
   endtask

   function automatic bit all_done();
      bit d;
      d = (m_owner < 0);
      for (int i = 0; i < NR; i++) if (q_len[i].size() > 0) d = 1'b0;
      return d;
   endfunction

   task automatic run_until_done(input string name, input int max_cycles);
      int n;
      n = 0;
      while (!all_done() && n < max_cycles) begin
         step();
         n++;
      end
      if (!all_done()) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: still busy after %0d cycles", name, n);
      end
   endtask

   // Entered just after a rising edge: drops reset between edges.
   task automatic reset_pulse(input string name);
      #2;
      rst_n = 1'b0;
      #1;
      check_val({name, "_grant"}, 32'(grant), 32'd0);
      check_val({name, "_busy"},  32'(busy), 32'd0);
      check_val({name, "_valid"}, 32'(uart_valid), 32'd0);
      check_val({name, "_ready"}, 32'(req_ready), 32'd0);
      check_val({name, "_data"},  32'(uart_data), 32'd0);
      flush_producers();
      clear_logs();
      m_owner = -1; m_ptr = 0; m_left = 0; m_hdr = 1'b0;
      drive_inputs();
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      bit stalled;
      int bad_grant;

      rst_n = 1'b0;
      uart_ready = 1'b1;
      req_valid = '0; req_len = '0; req_data = '0;
      flush_producers();
      drive_inputs();
      step();
      step();
      check_val("reset_grant", 32'(grant), 32'd0);
      check_val("reset_busy",  32'(busy), 32'd0);
      check_val("reset_valid", 32'(uart_valid), 32'd0);
      check_val("reset_data",  32'(uart_data), 32'd0);
      rst_n = 1'b1;
      step();

      // Single request from requester 2, three bytes.
      clear_logs();
      enq(2, 2, 8'h41);
      drive_inputs();
      step();
      check_val("t1_grant_t1", 32'(grant), 32'h4);
      check_val("t1_busy_t1",  32'(busy), 32'd1);
      run_until_done("t1", 50);
      exp_msg(2, 2, 8'h41);
      check_stream("t1_stream");
      check_val("t1_idle", 32'(busy), 32'd0);

      // All four together from reset, single-byte messages.
      reset_pulse("t2_rst");
      for (int i = 0; i < NR; i++) enq(i, 0, 8'hA0 + i);
      drive_inputs();
      run_until_done("t2", 100);
      for (int i = 0; i < NR; i++) begin
         exp_msg(i, 0, 8'hA0 + i);
         exp_g.push_back(i);
      end
      check_stream("t2_stream");
      check_grants("t2_order");

      // Requester 1 re-requests while 3 is pending.
      clear_logs();
      enq(1, 0, 8'h51);
      enq(1, 0, 8'h52);
      enq(3, 0, 8'h71);
      drive_inputs();
      run_until_done("t3", 100);
      exp_msg(1, 0, 8'h51); exp_msg(3, 0, 8'h71); exp_msg(1, 0, 8'h52);
      exp_g.push_back(1); exp_g.push_back(3); exp_g.push_back(1);
      check_stream("t3_stream");
      check_grants("t3_order");

      // Backpressure toggling plus a 3-cycle source stall mid-message.
      clear_logs();
      ready_mode = 1;
      enq(0, 3, 8'h10);
      drive_inputs();
      stalled = 1'b0;
      bad_grant = 0;
      n = 0;
      while (!all_done() && n < 100) begin
         if (!stalled && log_q.size() == HDR + 2) begin
            stall_cnt[0] = 3;
            stalled = 1'b1;
            drive_inputs();
         end
         step();
         if (busy && grant !== 4'b0001) bad_grant++;
         n++;
      end
      exp_msg(0, 3, 8'h10);
      check_stream("t4_stream");
      check_val("t4_stall_hit", 32'(stalled), 32'd1);
      check_val("t4_grant_hold", 32'(bad_grant), 32'd0);
      exp_g.push_back(0);
      check_grants("t4_order");
      ready_mode = 0;
      uart_ready = 1'b1;

      // Maximum length message.
      clear_logs();
      enq(1, 15, 8'hC0);
      drive_inputs();
      run_until_done("t5", 100);
      exp_msg(1, 15, 8'hC0);
      check_stream("t5_stream");
      check_val("t5_idle", 32'(busy), 32'd0);

      // Reset while the second payload byte is on the channel.
      clear_logs();
      enq(3, 5, 8'hE0);
      drive_inputs();
      n = 0;
      while (log_q.size() < HDR + 1 && n < 30) begin
         step();
         n++;
      end
      check_val("t6_reached_byte2", 32'(log_q.size()), 32'(HDR + 1));
      reset_pulse("t6_rst");
      enq(2, 0, 8'h2A);
      enq(0, 0, 8'h0A);
      drive_inputs();
      run_until_done("t6", 100);
      exp_g.push_back(0); exp_g.push_back(2);
      check_grants("t6_order");

      // Random traffic: random lengths, stalls, backpressure, length noise.
      clear_logs();
      ready_mode = 2;
      stall_pct = 20;
      garbage_len = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(9) == 0) begin
            int i;
            i = $urandom_range(NR - 1);
            if (q_len[i].size() < 2) enq(i, $urandom_range(15), $urandom);
            drive_inputs();
         end
         step();
      end
      run_until_done("rand", 8000);
      check_val("rand_idle", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit channel (the `UART` core's `DataIn`/`DataInValid`/`DataInReady` port) between `NumReq` requesters. Messages are granted round-robin and locked for their full length, so bytes from different sources never interleave on the serial line. When compiled in, a header byte carrying the source ID and length precedes each message. Sits between debug/status producers and the `UART` core's transmit side.

## Interface
- `NumReq`, 4: number of requesters, 2..8.
- `Width`, 8: UART word width; must match `UART.Width`.
- `LenWidth`, 4: message length field width. Message length is `ReqLen + 1` bytes, i.e. 1..2^LenWidth.
- `Clock` in, 1: system clock; all state changes on the rising edge.
- `Reset` in, 1: asynchronous, active-low reset.
- `ReqValid` in, NumReq: per-requester data valid; asserted = message pending or byte available.
- `ReqLen` in, NumReq*LenWidth: per-requester length, slice i = `[i*LenWidth +: LenWidth]`; sampled only at grant.
- `ReqData` in, NumReq*Width: per-requester byte, slice i = `[i*Width +: Width]`.
- `ReqReady` out, NumReq: per-requester byte accepted when `ReqValid[i] && ReqReady[i]`.
- `UARTData` out, Width: connects to `UART.DataIn`.
- `UARTValid` out, 1: connects to `UART.DataInValid`.
- `UARTReady` in, 1: connects to `UART.DataInReady`.
- `Grant` out, NumReq: one-hot owner of the channel; all zeros when idle.
- `Busy` out, 1: high whenever state is not IDLE.

## Operation
- States: IDLE, HEADER, DATA.
- IDLE: `ReqValid` is scanned starting at round-robin pointer `Ptr`. The first set bit wins. The winner's `ReqLen` is latched into `Count`, `Grant` is set to the winner, and the state moves to HEADER (macro defined) or DATA (macro undefined). With no request, the block stays in IDLE.
- HEADER:
  - `UARTData = {zeros, id[clog2(NumReq)-1:0], len[LenWidth-1:0]}`, `UARTValid=1`.
  - Moves to DATA on `UARTReady`. No `ReqReady` is asserted.
  - Elaboration error if `clog2(NumReq)+LenWidth > Width`.
- DATA:
  - `UARTData = ReqData[g]`, `UARTValid = ReqValid[g]`, `ReqReady[g] = UARTReady`. All other `ReqReady` are 0.
  - On each handshake, `Count` decrements.
  - A handshake with `Count==0` returns to IDLE, clears `Grant`, and sets `Ptr = g+1` (mod `NumReq`).
- Deasserting `ReqValid[g]` mid-message stalls the transfer. There is no abort and no timeout; the owner keeps the grant.
- Changes to `ReqLen` or to non-granted requests during a message are ignored.
- Count arithmetic is unsigned, `LenWidth` bits wide. `ReqLen` = all ones gives 2^LenWidth bytes.

## Timing
- Reset values: `Grant=0`, `Busy=0`, `UARTValid=0`, `ReqReady=0`, `UARTData=0`, `Ptr=0`, state IDLE, `Count=0`.
- Grant latency: `ReqValid` high in cycle t while IDLE gives `Grant`/`Busy` in cycle t+1, and first `UARTValid` in t+1.
- Throughput: one byte per cycle when `UARTReady` stays high. Each message costs 1 idle arbitration cycle plus 1 header cycle (if enabled) of overhead.
- Outputs are combinational from registered state plus the granted requester's inputs. There is no combinational path from `ReqValid[i≠g]`.
- Simultaneous requests: the winner is the lowest index at or after `Ptr`. A requester still asserting after completion loses to any other pending requester.
- Reset mid-message: immediate return to IDLE with all outputs at reset values. The partial message is dropped and the UART may still finish its current word.

## Configuration
- `UART_ARB_HEADER_EN`
  - Defined: HEADER state present; every message is prefixed by one header byte.
  - Undefined: HEADER state and its logic are removed; IDLE goes directly to DATA, and the serial stream is raw payload only.

## Structure
- Shared package `UARTArbPkg`:
  - state encoding enum (IDLE/HEADER/DATA);
  - the header field layout constants;
  - the `clog2` helper.
- One sub-module, `rr_priority_select`: a combinational round-robin priority picker (inputs `Req`, `Ptr`; outputs one-hot and index, plus a valid flag), reusable by other arbiters.

## Test plan
- Single request, header on: requester 2 sends `ReqLen=2` with data `0x41,0x42,0x43` while `UARTReady` is always 1.
  - Grant `0100` at t+1.
  - UART sees `0x22, 0x41, 0x42, 0x43`.
  - Back to IDLE after 4 handshakes.
- All four requesters assert together from reset, each with `ReqLen=0`.
  - Service order is 0, 1, 2, 3.
  - The header bytes across the four messages are `0x00`, `0x10`, `0x20`, `0x30`.
- Requester 1 keeps requesting after its message while 3 is pending: the next grant is 3, then 1.
- Backpressure and stalls: during requester 0's 4-byte message, toggle `UARTReady` every cycle and drop `ReqValid[0]` for 3 cycles mid-message.
  - Exactly 4 payload bytes arrive, in order, with no duplicates.
  - `Grant` stays `0001` throughout.
- Maximum length: `ReqLen=15` gives 16 payload bytes, then return to IDLE. `Count` must not wrap early.
- Assert `Reset` low during byte 2 of a message.
  - All outputs are 0 in the same cycle (asynchronous reset).
  - After release, the first grant goes to requester 0.
